// File: rtl/shift_vector_pkg.sv
// Shared types for the ordered shift vector: FSM states, shift direction and
// the strobe priority decode.
package shift_vector_pkg;

    typedef enum logic [1:0] {
        READY       = 2'd0,
        SHIFT_READ  = 2'd1,
        SHIFT_WRITE = 2'd2,
        FINISH      = 2'd3
    } state_e;

    typedef enum logic {
        DIR_INSERT = 1'b0,
        DIR_REMOVE = 1'b1
    } dir_e;

    typedef enum logic [2:0] {
        OP_NONE   = 3'd0,
        OP_GET    = 3'd1,
        OP_SET    = 3'd2,
        OP_INSERT = 3'd3,
        OP_REMOVE = 3'd4,
        OP_CLEAR  = 3'd5
    } op_e;

    // Highest-priority strobe wins; the rest of the same cycle are dropped.
    function automatic op_e decode_op(input logic get,
                                      input logic set,
                                      input logic insert,
                                      input logic remove,
                                      input logic clear);
        op_e op;
        op = OP_NONE;
        if (get)
            op = OP_GET;
        else if (set)
            op = OP_SET;
        else if (insert)
            op = OP_INSERT;
        else if (remove)
            op = OP_REMOVE;
        else if (clear)
            op = OP_CLEAR;
        return op;
    endfunction

endpackage

// File: rtl/shift_vector_if.sv
// Command/status bundle of the shift vector; master drives strobes, slave is the vector.
interface shift_vector_if #(
    parameter int DATA_WIDTH = 8,
    parameter int DATA_COUNT = 127
);
    localparam int INDEX_WIDTH  = $clog2(DATA_COUNT);
    localparam int LENGTH_WIDTH = $clog2(DATA_COUNT + 1);

    logic [INDEX_WIDTH-1:0]  index;
    logic                    get;
    logic                    set;
    logic                    insert;
    logic                    remove;
    logic                    clear;
    logic [DATA_WIDTH-1:0]   data_in;
    logic [DATA_WIDTH-1:0]   data_out;
    logic [LENGTH_WIDTH-1:0] length;
    logic                    full;
    logic                    empty;
    logic                    ready;
    logic                    done;
    logic                    error;

    modport master (
        output index, get, set, insert, remove, clear, data_in,
        input  data_out, length, full, empty, ready, done, error
    );

    modport slave (
        input  index, get, set, insert, remove, clear, data_in,
        output data_out, length, full, empty, ready, done, error
    );

endinterface

// File: rtl/shift_vector_mem.sv
// Single-port element store with registered read into either the visible
// read register (data_out) or the shift holding register (tmp).
module vector_mem #(
    parameter int DATA_WIDTH = 8,
    parameter int DATA_COUNT = 127,
    parameter int ADDR_WIDTH = 7
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic                  we,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  rd_out,
    input  logic                  rd_tmp,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic [DATA_WIDTH-1:0] tmp
);

    logic [DATA_WIDTH-1:0] mem [DATA_COUNT];

    // Array contents survive reset on purpose.
    always_ff @(posedge clk) begin
        if (we)
            mem[addr] <= wdata;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_out <= '0;
            tmp      <= '0;
        end else begin
            if (rd_out)
                data_out <= mem[addr];
            if (rd_tmp)
                tmp <= mem[addr];
        end
    end

endmodule

// File: rtl/shift_vector.sv
// Dense ordered vector with get/set/insert/remove/clear; insert and remove
// move the tail one element per read/write cycle pair.
module shift_vector
    import shift_vector_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DATA_COUNT = 127
) (
    input  logic           clk,
    input  logic           rst,
    shift_vector_if.slave  bus
);

    localparam int INDEX_WIDTH  = $clog2(DATA_COUNT);
    localparam int LENGTH_WIDTH = $clog2(DATA_COUNT + 1);

    typedef logic [LENGTH_WIDTH-1:0] len_t;
    typedef logic [INDEX_WIDTH-1:0]  idx_t;
    typedef logic [DATA_WIDTH-1:0]   dat_t;

    state_e state, state_next;
    dir_e   dir_q, dir_next;
    len_t   length_q, length_next;
    len_t   j_q, j_next;
    idx_t   index_q, index_next;
    dat_t   data_q, data_next;
    logic   done_q, done_next;
    logic   error_q, error_next;

    idx_t   mem_addr;
    logic   mem_we;
    dat_t   mem_wdata;
    logic   rd_out;
    logic   rd_tmp;
    dat_t   rd_data;
    dat_t   tmp;

    len_t   idx_ext;
    len_t   j_dec;
    len_t   j_inc;
    len_t   len_dec;
    op_e    op;

    assign idx_ext = len_t'(bus.index);
    assign j_dec   = j_q - len_t'(1);
    assign j_inc   = j_q + len_t'(1);
    assign len_dec = length_q - len_t'(1);
    assign op      = decode_op(bus.get, bus.set, bus.insert, bus.remove, bus.clear);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= READY;
            dir_q    <= DIR_INSERT;
            length_q <= '0;
            j_q      <= '0;
            index_q  <= '0;
            data_q   <= '0;
            done_q   <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            state    <= state_next;
            dir_q    <= dir_next;
            length_q <= length_next;
            j_q      <= j_next;
            index_q  <= index_next;
            data_q   <= data_next;
            done_q   <= done_next;
            error_q  <= error_next;
        end
    end

    always_comb begin
        state_next  = state;
        dir_next    = dir_q;
        length_next = length_q;
        j_next      = j_q;
        index_next  = index_q;
        data_next   = data_q;
        done_next   = 1'b0;
        error_next  = 1'b0;
        mem_addr    = bus.index;
        mem_we      = 1'b0;
        mem_wdata   = bus.data_in;
        rd_out      = 1'b0;
        rd_tmp      = 1'b0;

        case (state)
            READY: begin
                case (op)
                    OP_GET: begin
                        done_next = 1'b1;
                        if (idx_ext >= length_q)
                            error_next = 1'b1;
                        else
                            rd_out = 1'b1;
                    end
                    OP_SET: begin
                        done_next = 1'b1;
                        if (idx_ext >= length_q)
                            error_next = 1'b1;
                        else
                            mem_we = 1'b1;
                    end
                    OP_INSERT: begin
                        if (length_q == len_t'(DATA_COUNT) || idx_ext > length_q) begin
                            done_next  = 1'b1;
                            error_next = 1'b1;
                        end else begin
                            index_next = bus.index;
                            data_next  = bus.data_in;
                            dir_next   = DIR_INSERT;
                            if (idx_ext == length_q) begin
                                state_next = FINISH;
                            end else begin
                                j_next     = length_q;
                                state_next = SHIFT_READ;
                            end
                        end
                    end
                    OP_REMOVE: begin
                        if (length_q == '0 || idx_ext >= length_q) begin
                            done_next  = 1'b1;
                            error_next = 1'b1;
                        end else begin
                            index_next = bus.index;
                            dir_next   = DIR_REMOVE;
                            if (idx_ext == len_dec) begin
                                state_next = FINISH;
                            end else begin
                                j_next     = idx_ext;
                                state_next = SHIFT_READ;
                            end
                        end
                    end
                    OP_CLEAR: begin
                        length_next = '0;
                        done_next   = 1'b1;
                    end
                    default: ;
                endcase
            end

            // Insert walks j down from the old end, remove walks j up from the hole.
            SHIFT_READ: begin
                rd_tmp     = 1'b1;
                mem_addr   = (dir_q == DIR_INSERT) ? j_dec[INDEX_WIDTH-1:0]
                                                   : j_inc[INDEX_WIDTH-1:0];
                state_next = SHIFT_WRITE;
            end

            SHIFT_WRITE: begin
                mem_we    = 1'b1;
                mem_addr  = j_q[INDEX_WIDTH-1:0];
                mem_wdata = tmp;
                if (dir_q == DIR_INSERT) begin
                    j_next     = j_dec;
                    state_next = (j_dec == len_t'(index_q)) ? FINISH : SHIFT_READ;
                end else begin
                    j_next     = j_inc;
                    state_next = (j_inc == len_dec) ? FINISH : SHIFT_READ;
                end
            end

            FINISH: begin
                mem_addr   = index_q;
                done_next  = 1'b1;
                state_next = READY;
                if (dir_q == DIR_INSERT) begin
                    mem_we      = 1'b1;
                    mem_wdata   = data_q;
                    length_next = length_q + len_t'(1);
                end else begin
                    length_next = len_dec;
                end
            end

            default: state_next = READY;
        endcase
    end

    vector_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DATA_COUNT (DATA_COUNT),
        .ADDR_WIDTH (INDEX_WIDTH)
    ) u_mem (
        .clk      (clk),
        .rst      (rst),
        .addr     (mem_addr),
        .we       (mem_we & ~rst),
        .wdata    (mem_wdata),
        .rd_out   (rd_out),
        .rd_tmp   (rd_tmp),
        .data_out (rd_data),
        .tmp      (tmp)
    );

    assign bus.data_out = rd_data;
    assign bus.length   = length_q;
    assign bus.full     = (length_q == len_t'(DATA_COUNT));
    assign bus.empty    = (length_q == '0);
    assign bus.ready    = (state == READY);
    assign bus.done     = done_q;
    assign bus.error    = error_q;

endmodule

// File: tb/tb_shift_vector.sv
// Directed bench for shift_vector (DATA_COUNT=4) with a reference queue model
// and a scoreboard of expected completions.
module tb_shift_vector;

    localparam int DW = 8;
    localparam int DC = 4;

    typedef struct {
        string      tag;
        logic       err;
        int         lat;
        int         len;
        logic [7:0] dout;
    } exp_t;

    localparam logic [4:0] S_GET    = 5'b00001;
    localparam logic [4:0] S_SET    = 5'b00010;
    localparam logic [4:0] S_INSERT = 5'b00100;
    localparam logic [4:0] S_REMOVE = 5'b01000;
    localparam logic [4:0] S_CLEAR  = 5'b10000;

    logic clk = 1'b0;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;

    logic [7:0] model[$];
    logic [7:0] m_dout = 8'h00;
    exp_t       sb[$];

    always #5 clk = ~clk;

    shift_vector_if #(.DATA_WIDTH(DW), .DATA_COUNT(DC)) bus ();

    shift_vector #(.DATA_WIDTH(DW), .DATA_COUNT(DC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic do_op(input logic [4:0] strobes, input int idx,
                         input logic [7:0] din, input string tag);
        exp_t e;
        int   n;
        int   lat;
        int   cyc;
        n     = model.size();
        e.tag = tag;
        e.err = 1'b0;
        e.lat = 0;
        if (strobes[0]) begin
            if (idx < n) m_dout = model[idx]; else e.err = 1'b1;
        end else if (strobes[1]) begin
            if (idx < n) model[idx] = din; else e.err = 1'b1;
        end else if (strobes[2]) begin
            if (n < DC && idx <= n) begin
                e.lat = 2 * (n - idx) + 1;
                model.insert(idx, din);
            end else e.err = 1'b1;
        end else if (strobes[3]) begin
            if (n > 0 && idx < n) begin
                e.lat = 2 * (n - 1 - idx) + 1;
                model.delete(idx);
            end else e.err = 1'b1;
        end else if (strobes[4]) begin
            model.delete();
        end
        e.len  = model.size();
        e.dout = m_dout;
        sb.push_back(e);

        @(negedge clk);
        check({tag, "/ready_before"}, 32'(bus.ready), 32'd1);
        bus.index   = 2'(idx);
        bus.data_in = din;
        {bus.clear, bus.remove, bus.insert, bus.set, bus.get} = strobes;
        @(posedge clk);
        #1;
        {bus.clear, bus.remove, bus.insert, bus.set, bus.get} = '0;
        bus.data_in = 8'hEE;
        bus.index   = '0;
        lat = 0;
        cyc = 0;
        while (bus.done !== 1'b1 && cyc < 40) begin
            if (bus.ready !== 1'b1) lat++;
            cyc++;
            @(posedge clk);
            #1;
        end
        e = sb.pop_front();
        check({e.tag, "/done"},     32'(bus.done),     32'd1);
        check({e.tag, "/error"},    32'(bus.error),    32'(e.err));
        check({e.tag, "/latency"},  32'(lat),          32'(e.lat));
        check({e.tag, "/length"},   32'(bus.length),   32'(e.len));
        check({e.tag, "/data_out"}, 32'(bus.data_out), 32'(e.dout));
        check({e.tag, "/full"},     32'(bus.full),     32'(e.len == DC));
        check({e.tag, "/empty"},    32'(bus.empty),    32'(e.len == 0));
        check({e.tag, "/ready"},    32'(bus.ready),    32'd1);
    endtask

    initial begin
        rst = 1'b1;
        {bus.clear, bus.remove, bus.insert, bus.set, bus.get} = '0;
        bus.index   = '0;
        bus.data_in = '0;
        @(posedge clk);
        @(posedge clk);
        #1;
        check("reset/length",   32'(bus.length),   32'd0);
        check("reset/empty",    32'(bus.empty),    32'd1);
        check("reset/full",     32'(bus.full),     32'd0);
        check("reset/ready",    32'(bus.ready),    32'd1);
        check("reset/data_out", 32'(bus.data_out), 32'h00);
        check("reset/done",     32'(bus.done),     32'd0);
        @(negedge clk);
        rst = 1'b0;

        do_op(S_INSERT, 0, 8'h11, "ins_0_11_empty");
        do_op(S_INSERT, 0, 8'h22, "ins_0_22_shift");
        do_op(S_GET,    0, 8'h00, "get0_22");
        do_op(S_GET,    1, 8'h00, "get1_11");

        do_op(S_INSERT, 2, 8'h33, "ins_2_33_append");
        do_op(S_INSERT, 3, 8'h44, "ins_3_44_append");
        do_op(S_INSERT, 2, 8'h55, "ins_full_rejected");
        for (int i = 0; i < DC; i++) do_op(S_GET, i, 8'h00, "get_after_full");

        do_op(S_REMOVE, 0, 8'h00, "rem_0_long_shift");
        for (int i = 0; i < 3; i++) do_op(S_GET, i, 8'h00, "get_after_rem0");
        do_op(S_REMOVE, 2, 8'h00, "rem_last");
        do_op(S_INSERT, 1, 8'h99, "ins_1_99_mid");

        do_op(S_GET,    3, 8'h00, "get_oob");
        do_op(S_SET,    3, 8'h77, "set_oob");
        do_op(S_SET,    1, 8'h55, "set_1_55");
        do_op(S_GET,    1, 8'h00, "get_1_55");
        do_op(S_GET | S_REMOVE, 0, 8'h00, "get_wins_over_remove");
        do_op(S_INSERT | S_CLEAR, 3, 8'hA5, "insert_wins_over_clear");
        do_op(S_REMOVE, 4'd3 + 0, 8'h00, "rem_end_after_ins");
        do_op(S_CLEAR,  0, 8'h00, "clear");
        do_op(S_REMOVE, 0, 8'h00, "rem_empty_rejected");
        do_op(S_GET,    0, 8'h00, "get_empty_rejected");

        for (int i = 0; i < DC; i++) do_op(S_INSERT, i, 8'(8'hC0 + i), "refill");

        // Abort a remove(0) while it is in SHIFT_WRITE.
        @(negedge clk);
        bus.index  = '0;
        bus.remove = 1'b1;
        @(posedge clk);
        #1;
        bus.remove = 1'b0;
        check("abort/ready_low_read", 32'(bus.ready), 32'd0);
        @(posedge clk);
        #1;
        check("abort/ready_low_write", 32'(bus.ready), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        model.delete();
        m_dout = 8'h00;
        check("abort/ready",    32'(bus.ready),    32'd1);
        check("abort/length",   32'(bus.length),   32'd0);
        check("abort/empty",    32'(bus.empty),    32'd1);
        check("abort/done",     32'(bus.done),     32'd0);
        check("abort/data_out", 32'(bus.data_out), 32'h00);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("abort/no_late_done", 32'(bus.done), 32'd0);

        do_op(S_INSERT, 0, 8'h66, "ins_after_abort");
        do_op(S_GET,    0, 8'h00, "get_after_abort");

        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
